// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with a begin-timeout on idle grants and a watchdog
// that forces an end/error pulse when a started transaction never completes.
module bus_arbiter #(
    parameter int NUM_MASTERS   = 4,
    parameter int BEGIN_TIMEOUT = 16,
    parameter int BUS_TIMEOUT   = 1024
) (
    input  logic                   system_clock,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] request,
    output logic [NUM_MASTERS-1:0] granted,
    input  logic                   begin_transactionIN,
    input  logic                   end_transactionIN,
    input  logic                   errorIN,
    output logic                   end_transactionOUT,
    output logic                   errorOUT,
    output logic                   busy
);

    localparam int IDX_W  = $clog2(NUM_MASTERS);
    localparam int BCNT_W = $clog2(BEGIN_TIMEOUT) + 1;
    localparam int WCNT_W = $clog2(BUS_TIMEOUT) + 1;

    typedef enum logic [1:0] {
        IDLE,
        GRANTED,
        ACTIVE,
        RELEASE
    } state_t;

    state_t                 state, state_n;
    logic [IDX_W-1:0]       last, last_n;
    logic [BCNT_W-1:0]      bcnt, bcnt_n;
    logic [WCNT_W-1:0]      wcnt, wcnt_n;
    logic [NUM_MASTERS-1:0] granted_n;
    logic                   busy_n;
    logic                   force_pulse, force_pulse_n;

    logic [IDX_W-1:0]       winner;
    logic [IDX_W-1:0]       cand;
    logic                   found;

    // Bus errors are resolved by the owning master; only end releases the bus.
    logic unused_error;
    assign unused_error = errorIN;

    // Round-robin search starting just above the previous winner.
    always_comb begin
        winner = last;
        cand   = '0;
        found  = 1'b0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand = IDX_W'((int'(last) + i) % NUM_MASTERS);
            if (!found && request[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_n       = state;
        last_n        = last;
        bcnt_n        = bcnt;
        wcnt_n        = wcnt;
        granted_n     = granted;
        force_pulse_n = 1'b0;

        case (state)
            IDLE: begin
                granted_n = '0;
                if (found) begin
                    state_n           = GRANTED;
                    last_n            = winner;
                    bcnt_n            = '0;
                    granted_n[winner] = 1'b1;
                end
            end
            GRANTED: begin
                if (!request[last]) begin
                    state_n   = RELEASE;
                    granted_n = '0;
                end else if (begin_transactionIN) begin
                    state_n = ACTIVE;
                    wcnt_n  = '0;
                end else if (bcnt == BCNT_W'(BEGIN_TIMEOUT - 1)) begin
                    state_n   = RELEASE;
                    granted_n = '0;
                end else begin
                    bcnt_n = bcnt + BCNT_W'(1);
                end
            end
            ACTIVE: begin
                // The forced pulse cycle keeps the grant; release follows it.
                if (end_transactionIN || force_pulse) begin
                    state_n   = RELEASE;
                    granted_n = '0;
                end else if (wcnt == WCNT_W'(BUS_TIMEOUT - 1)) begin
                    force_pulse_n = 1'b1;
                end else begin
                    wcnt_n = wcnt + WCNT_W'(1);
                end
            end
            RELEASE: begin
                state_n   = IDLE;
                granted_n = '0;
            end
            default: begin
                state_n   = IDLE;
                granted_n = '0;
            end
        endcase

        busy_n = (state_n == GRANTED) || (state_n == ACTIVE);
    end

    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            last        <= IDX_W'(NUM_MASTERS - 1);
            bcnt        <= '0;
            wcnt        <= '0;
            granted     <= '0;
            busy        <= 1'b0;
            force_pulse <= 1'b0;
        end else begin
            state       <= state_n;
            last        <= last_n;
            bcnt        <= bcnt_n;
            wcnt        <= wcnt_n;
            granted     <= granted_n;
            busy        <= busy_n;
            force_pulse <= force_pulse_n;
        end
    end

    assign end_transactionOUT = force_pulse;
    assign errorOUT           = force_pulse;

endmodule
